// File: rtl/wishbone_sram_slave.sv
// Wishbone classic slave that bridges 32-bit single transfers onto an
// asynchronous SRAM, with a programmable access pulse length.
module wishbone_sram_slave #(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wishbone_cyc_i,
  input  logic               wishbone_stb_i,
  input  logic [31:0]        wishbone_addr_i,
  input  logic [31:0]        wishbone_data_i,
  input  logic               wishbone_we_i,
  input  logic [15:0]        wishbone_select_i,
  output logic [31:0]        wishbone_data_o,
  output logic               wishbone_ack_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_data_o,
  input  logic [31:0]        sram_data_i,
  output logic               sram_data_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_ACK
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t              r_state, w_next;
  logic [3:0]          r_cnt, w_cnt_next;
  logic                r_abort, w_abort_next;
  logic [SRAM_AW-1:0]  r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic [3:0]          r_sel;
  logic                w_accept;
  logic                w_capture;
  logic                w_unused;

  // Byte-offset, upper address bits and upper select lanes carry no meaning here.
  assign w_unused = ^{wishbone_addr_i, wishbone_select_i[15:4]};

  assign sram_addr_o     = r_addr;
  assign sram_data_o     = r_wdata;
  assign wishbone_data_o = r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_abort <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_abort <= w_abort_next;
      if (w_accept) begin
        r_addr  <= wishbone_addr_i[SRAM_AW+1:2];
        r_wdata <= wishbone_data_i;
        r_sel   <= wishbone_select_i[3:0];
      end
      if (w_capture) r_rdata <= sram_data_i;
    end
  end

  // Strobes are decoded straight from the registered state so that an
  // asynchronous reset releases the SRAM pins in the same cycle.
  always_comb begin
    w_next         = r_state;
    w_cnt_next     = r_cnt;
    w_abort_next   = r_abort;
    w_accept       = 1'b0;
    w_capture      = 1'b0;
    wishbone_ack_o = 1'b0;
    sram_ce_n      = 1'b1;
    sram_oe_n      = 1'b1;
    sram_we_n      = 1'b1;
    sram_data_oe   = 1'b0;
    sram_be_n      = 4'b1111;
    case (r_state)
      S_IDLE: begin
        w_abort_next = 1'b0;
        if (wishbone_cyc_i && wishbone_stb_i) begin
          w_accept   = 1'b1;
          w_cnt_next = CNT_LOAD;
          w_next     = wishbone_we_i ? S_WR_SETUP : S_RD;
        end
      end
      S_RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_be_n = 4'b0000;
        if (!wishbone_cyc_i) begin
          w_next     = S_IDLE;
          w_cnt_next = '0;
        end else if (r_cnt == 4'd0) begin
          w_capture = 1'b1;
          w_next    = S_ACK;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_WR_SETUP: begin
        sram_ce_n    = 1'b0;
        sram_data_oe = 1'b1;
        sram_be_n    = ~r_sel;
        w_cnt_next   = CNT_LOAD;
        w_next       = S_WR_PULSE;
        if (!wishbone_cyc_i) w_abort_next = 1'b1;
      end
      S_WR_PULSE: begin
        sram_ce_n    = 1'b0;
        sram_data_oe = 1'b1;
        sram_be_n    = ~r_sel;
        // An all-zero select writes nothing, so the pulse is suppressed.
        sram_we_n    = (r_sel == 4'b0000);
        if (!wishbone_cyc_i) w_abort_next = 1'b1;
        if (r_cnt == 4'd0) w_next = S_WR_HOLD;
        else               w_cnt_next = r_cnt - 4'd1;
      end
      S_WR_HOLD: begin
        sram_ce_n    = 1'b0;
        sram_data_oe = 1'b1;
        sram_be_n    = ~r_sel;
        w_next       = (r_abort || !wishbone_cyc_i) ? S_IDLE : S_ACK;
      end
      S_ACK: begin
        wishbone_ack_o = 1'b1;
        w_next         = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wishbone_sram_slave.sv
// Directed bench for wishbone_sram_slave at default parameters (WAIT_CYCLES=2).
module tb_wishbone_sram_slave;

  logic        clk, rst;
  logic        cyc, stb, we;
  logic [31:0] addr, wdata;
  logic [15:0] sel;
  logic [31:0] rdata_o;
  logic        ack;
  logic [19:0] s_addr;
  logic [31:0] s_dout, s_din;
  logic        s_doe, ce_n, oe_n, we_n;
  logic [3:0]  be_n;

  int checks = 0;
  int errors = 0;

  // per-transfer observations
  int          ack_first, ack_cnt, oe_low, we_low, ce_low, doe_cnt, we_first;
  logic        overlap, unstable, we_c1, we_c4;
  logic [19:0] addr_c1;
  logic [31:0] sdo_c1;
  logic [3:0]  be_c1;

  wishbone_sram_slave dut (
    .clk(clk), .rst(rst),
    .wishbone_cyc_i(cyc), .wishbone_stb_i(stb),
    .wishbone_addr_i(addr), .wishbone_data_i(wdata),
    .wishbone_we_i(we), .wishbone_select_i(sel),
    .wishbone_data_o(rdata_o), .wishbone_ack_o(ack),
    .sram_addr_o(s_addr), .sram_data_o(s_dout), .sram_data_i(s_din),
    .sram_data_oe(s_doe), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
    .sram_we_n(we_n), .sram_be_n(be_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request, then observe 8 cycles; cycle 1 is the one right after
  // the acceptance edge. cyc drops at drop_at (if nonzero) or once ack is seen.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [15:0] s, input int drop_at);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
    ack_first = 0; ack_cnt = 0; oe_low = 0; we_low = 0; ce_low = 0;
    doe_cnt = 0; we_first = 0; overlap = 1'b0; unstable = 1'b0;
    we_c1 = 1'b0; we_c4 = 1'b0; addr_c1 = '0; sdo_c1 = '0; be_c1 = '0;
    @(posedge clk);
    #1 stb = 1'b0;
    addr = 32'hFFFF_FFFC; wdata = 32'h0BAD_0BAD; sel = 16'hFFFF;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        addr_c1 = s_addr; sdo_c1 = s_dout; be_c1 = be_n; we_c1 = we_n;
      end
      if (c == 4) we_c4 = we_n;
      if (ack) begin
        if (ack_first == 0) ack_first = c;
        ack_cnt++;
      end
      if (!oe_n) oe_low++;
      if (!ce_n) ce_low++;
      if (s_doe) doe_cnt++;
      if (!we_n) begin
        if (we_first == 0) we_first = c;
        we_low++;
      end
      if (!oe_n && s_doe) overlap = 1'b1;
      if (!ce_n && (s_addr !== addr_c1 || s_dout !== sdo_c1)) unstable = 1'b1;
      if (ack || c == drop_at) cyc = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; sel = '0; s_din = '0;
    #12;
    checks++;
    if ({ack, ce_n, oe_n, we_n, s_doe, be_n} !== {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111}) begin
      errors++;
      $display("FAIL reset_ctrl: got ack/ce/oe/we/doe/be=%b %b %b %b %b %b",
               ack, ce_n, oe_n, we_n, s_doe, be_n);
    end
    checks++;
    if (rdata_o !== 32'h0 || s_addr !== 20'h0 || s_dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: data_o=%h addr=%h sdata=%h expected zeros", rdata_o, s_addr, s_dout);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_idle_stb_only;
    int busy = 0;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b1; we = 1'b1; sel = 16'h000F;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (!ce_n || ack || s_doe) busy++;
    end
    stb = 1'b0;
    checks++;
    if (busy != 0) begin
      errors++;
      $display("FAIL stb_without_cyc: %0d busy cycles, expected 0", busy);
    end
  endtask

  task automatic test_read;
    s_din = 32'hDEADBEEF;
    xfer(1'b0, 32'h0000_0010, 32'h0, 16'h0000, 0);
    checks++;
    if (addr_c1 !== 20'h4) begin
      errors++; $display("FAIL read_addr: got %h expected 00004", addr_c1);
    end
    checks++;
    if (oe_low != 2) begin
      errors++; $display("FAIL read_oe_len: got %0d expected 2", oe_low);
    end
    checks++;
    if (ack_first != 3 || ack_cnt != 1) begin
      errors++; $display("FAIL read_ack: at %0d count %0d expected at 3 count 1", ack_first, ack_cnt);
    end
    checks++;
    if (be_c1 !== 4'b0000 || overlap || doe_cnt != 0) begin
      errors++; $display("FAIL read_pins: be=%b overlap=%b doe_cnt=%0d expected 0000 0 0", be_c1, overlap, doe_cnt);
    end
    s_din = 32'h0;
    checks++;
    if (rdata_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_data: got %h expected deadbeef", rdata_o);
    end
  endtask

  task automatic test_write;
    xfer(1'b1, 32'h0000_0008, 32'h11223344, 16'hFFF5, 0);
    checks++;
    if (addr_c1 !== 20'h2 || sdo_c1 !== 32'h11223344 || unstable) begin
      errors++; $display("FAIL write_addr_data: addr=%h data=%h unstable=%b expected 00002 11223344 0",
                         addr_c1, sdo_c1, unstable);
    end
    checks++;
    if (be_c1 !== 4'b1010) begin
      errors++; $display("FAIL write_be: got %b expected 1010", be_c1);
    end
    checks++;
    if (we_low != 2 || we_first != 2 || we_c1 !== 1'b1 || we_c4 !== 1'b1) begin
      errors++; $display("FAIL write_we_pulse: low=%0d first=%0d setup=%b hold=%b expected 2 2 1 1",
                         we_low, we_first, we_c1, we_c4);
    end
    checks++;
    if (doe_cnt != 4 || ce_low != 4) begin
      errors++; $display("FAIL write_doe_ce: doe=%0d ce=%0d expected 4 4", doe_cnt, ce_low);
    end
    checks++;
    if (ack_first != 5 || ack_cnt != 1) begin
      errors++; $display("FAIL write_ack: at %0d count %0d expected at 5 count 1", ack_first, ack_cnt);
    end
  endtask

  task automatic test_write_nosel;
    xfer(1'b1, 32'h0000_000C, 32'hAABBCCDD, 16'h0000, 0);
    checks++;
    if (we_low != 0 || be_c1 !== 4'b1111) begin
      errors++; $display("FAIL nosel_we: we_low=%0d be=%b expected 0 1111", we_low, be_c1);
    end
    checks++;
    if (ack_first != 5 || ack_cnt != 1) begin
      errors++; $display("FAIL nosel_ack: at %0d count %0d expected at 5 count 1", ack_first, ack_cnt);
    end
  endtask

  task automatic test_read_abort;
    s_din = 32'h12345678;
    xfer(1'b0, 32'h0000_0100, 32'h0, 16'h000F, 1);
    checks++;
    if (ack_cnt != 0 || ce_low != 1) begin
      errors++; $display("FAIL read_abort: acks=%0d ce_low=%0d expected 0 1", ack_cnt, ce_low);
    end
    checks++;
    if (rdata_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL abort_data_kept: got %h expected deadbeef", rdata_o);
    end
  endtask

  task automatic test_write_cyc_drop;
    xfer(1'b1, 32'h0000_0020, 32'h55667788, 16'h000F, 2);
    checks++;
    if (ack_cnt != 0 || we_low != 2 || ce_low != 4) begin
      errors++; $display("FAIL write_cyc_drop: acks=%0d we_low=%0d ce_low=%0d expected 0 2 4",
                         ack_cnt, we_low, ce_low);
    end
  endtask

  task automatic test_reset_midwrite;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hCAFE0001; sel = 16'h000F;
    @(posedge clk);
    #1 stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (we_n !== 1'b0) begin
      errors++; $display("FAIL midwrite_pulse: we_n=%b expected 0", we_n);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({we_n, ce_n, s_doe, oe_n, be_n, ack} !== {1'b1, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b0}) begin
      errors++; $display("FAIL midwrite_reset: we/ce/doe/oe/be/ack=%b %b %b %b %b %b",
                         we_n, ce_n, s_doe, oe_n, be_n, ack);
    end
    checks++;
    if (s_addr !== 20'h0 || s_dout !== 32'h0 || rdata_o !== 32'h0) begin
      errors++; $display("FAIL midwrite_regs: addr=%h sdata=%h data_o=%h expected zeros", s_addr, s_dout, rdata_o);
    end
    @(negedge clk); rst = 1'b0; cyc = 1'b0;
    s_din = 32'hCAFEF00D;
    xfer(1'b0, 32'h0000_0020, 32'h0, 16'h000F, 0);
    checks++;
    if (ack_first != 3 || addr_c1 !== 20'h8 || rdata_o !== 32'hCAFEF00D) begin
      errors++; $display("FAIL post_reset_read: ack_at=%0d addr=%h data=%h expected 3 00008 cafef00d",
                         ack_first, addr_c1, rdata_o);
    end
  endtask

  task automatic test_back_to_back;
    int   acks = 0;
    int   ack_a = 0, ack_b = 0;
    logic [31:0] d_a = '0, d_b = '0;
    logic [19:0] addr_b = '0;
    logic        idle_gap = 1'b0;
    @(negedge clk);
    s_din = 32'hA5A5A5A5;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h40; sel = 16'h000F;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 4) idle_gap = ce_n;
      if (c == 5) addr_b = s_addr;
      if (ack) begin
        acks++;
        if (ack_a == 0) begin ack_a = c; d_a = rdata_o; end
        else begin ack_b = c; d_b = rdata_o; cyc = 1'b0; stb = 1'b0; end
      end
      if (c == 3) begin s_din = 32'h5A5A5A5A; addr = 32'h44; end
    end
    cyc = 1'b0; stb = 1'b0;
    checks++;
    if (acks != 2 || ack_a != 3 || ack_b != 7) begin
      errors++; $display("FAIL b2b_ack: count=%0d at %0d,%0d expected 2 at 3,7", acks, ack_a, ack_b);
    end
    checks++;
    if (idle_gap !== 1'b1 || addr_b !== 20'h11) begin
      errors++; $display("FAIL b2b_gap: idle_ce_n=%b addr2=%h expected 1 00011", idle_gap, addr_b);
    end
    checks++;
    if (d_a !== 32'hA5A5A5A5 || d_b !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL b2b_data: %h %h expected a5a5a5a5 5a5a5a5a", d_a, d_b);
    end
  endtask

  initial begin
    test_reset();
    test_idle_stb_only();
    test_read();
    test_write();
    test_write_nosel();
    test_read_abort();
    test_write_cyc_drop();
    test_reset_midwrite();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
